// File: rtl/engine2vga_writer_pkg.sv
// Shared types and constants for the Mandelbrot-engine to VGA frame-buffer writer.
// Holds the pixel record, FSM encoding and the colour-index mapping.
`timescale 1ns/1ps
package engine2vga_writer_pkg;
  localparam int ITER_W    = 16;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int FB_ADDR_W = 19;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ITER_W-1:0] iter;
  } pix_t;

  // Index 0 is reserved for in-set points, so an escaped count whose low byte is 0 maps to 0xFF.
  function automatic logic [7:0] color_index(input logic [ITER_W-1:0] iter,
                                             input logic [ITER_W-1:0] max_iter);
    logic [7:0] idx;
    if (iter >= max_iter)
      idx = 8'd0;
    else if (iter[7:0] == 8'd0)
      idx = 8'hFF;
    else
      idx = iter[7:0];
    return idx;
  endfunction
endpackage

// File: rtl/engine2vga_writer_if.sv
// Pixel-result handshake from the engine plus the frame-buffer write port.
// The writer block uses the slave modport; the engine/frame-buffer side uses master.
`timescale 1ns/1ps
interface engine2vga_writer_if;
  import engine2vga_writer_pkg::*;

  logic                 iPix_valid;
  logic                 oPix_ready;
  logic [X_W-1:0]       iPix_x;
  logic [Y_W-1:0]       iPix_y;
  logic [ITER_W-1:0]    iPix_iter;
  logic                 oWR_en;
  logic [FB_ADDR_W-1:0] oADDR;
  logic [7:0]           oDATA;

  modport slave (
    input  iPix_valid, iPix_x, iPix_y, iPix_iter,
    output oPix_ready, oWR_en, oADDR, oDATA
  );

  modport master (
    output iPix_valid, iPix_x, iPix_y, iPix_iter,
    input  oPix_ready, oWR_en, oADDR, oDATA
  );
endinterface

// File: rtl/engine2vga_writer_pixel_fifo.sv
// First-word-fall-through pixel FIFO; head is visible the cycle after the push edge.
// Pushes while full and pops while empty are ignored; the caller gates both.
`timescale 1ns/1ps
module pixel_fifo
  import engine2vga_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  pix_t i_dat,
  input  logic i_pop,
  output pix_t o_dat,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);

  pix_t         r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

// File: rtl/engine2vga_writer.sv
// Buffers engine pixel results and writes {addr, colour} to the frame buffer; 3-cycle accept-to-write latency.
// Ready drops when the FIFO is full or while draining/clearing; a clear writes zeros over the whole screen.
`timescale 1ns/1ps
module engine2vga_writer
  import engine2vga_writer_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_iCLK,
  input  logic                 iRST_N,
  input  logic [ITER_W-1:0]    iMax_iter,
  input  logic                 iClear,
  engine2vga_writer_if.slave   pix_bus,
  output logic                 oBusy,
  output logic                 oDrop,
  output logic                 oFrame_done,
  output logic [FB_ADDR_W-1:0] oPix_count
);
  localparam logic [FB_ADDR_W-1:0] PIX_TOTAL = FB_ADDR_W'(H_RES * V_RES);
  localparam logic [FB_ADDR_W-1:0] PIX_LAST  = PIX_TOTAL - FB_ADDR_W'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rdy_en;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  pix_t                 w_in;
  pix_t                 w_head;
  logic                 w_in_range;
  logic [FB_ADDR_W-1:0] w_lin_addr;
  logic                 w_clr_last;

  logic                 r_s1_vld;
  logic                 r_s1_ok;
  logic [FB_ADDR_W-1:0] r_s1_addr;
  logic [7:0]           r_s1_dat;

  logic                 r_wr_en;
  logic                 r_drop;
  logic                 r_fdone;
  logic [FB_ADDR_W-1:0] r_addr;
  logic [7:0]           r_dat;
  logic [FB_ADDR_W-1:0] r_count;
  logic [FB_ADDR_W-1:0] r_clr_addr;

  assign w_ready = r_rdy_en && !w_full && (r_state == ST_RUN);
  assign w_push  = pix_bus.iPix_valid && w_ready;
  assign w_pop   = !w_empty && (r_state != ST_CLEAR);
  assign w_in    = '{x: pix_bus.iPix_x, y: pix_bus.iPix_y, iter: pix_bus.iPix_iter};

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk_iCLK),
    .i_rst_n (iRST_N),
    .i_push  (w_push),
    .i_dat   (w_in),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Constant multiplier; for 640 this reduces to (y<<9)+(y<<7)+x.
  assign w_in_range = (w_head.x < X_W'(H_RES)) && (w_head.y < Y_W'(V_RES));
  assign w_lin_addr = FB_ADDR_W'(w_head.y) * FB_ADDR_W'(H_RES) + FB_ADDR_W'(w_head.x);
  assign w_clr_last = (r_clr_addr == PIX_LAST);

  always_ff @(posedge clk_iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state  <= ST_RUN;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  // CLEAR is entered only once both the FIFO and stage 1 are empty.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:   if (iClear) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_empty && !r_s1_vld) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_s1_vld  <= 1'b0;
      r_s1_ok   <= 1'b0;
      r_s1_addr <= '0;
      r_s1_dat  <= '0;
    end else begin
      r_s1_vld  <= w_pop;
      r_s1_ok   <= w_in_range;
      r_s1_addr <= w_lin_addr;
      r_s1_dat  <= color_index(w_head.iter, iMax_iter);
    end
  end

  always_ff @(posedge clk_iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wr_en    <= 1'b0;
      r_drop     <= 1'b0;
      r_fdone    <= 1'b0;
      r_addr     <= '0;
      r_dat      <= '0;
      r_count    <= '0;
      r_clr_addr <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_drop  <= 1'b0;
      r_fdone <= 1'b0;
      if (r_state == ST_CLEAR) begin
        r_wr_en <= 1'b1;
        r_addr  <= r_clr_addr;
        r_dat   <= 8'd0;
        if (w_clr_last) begin
          r_clr_addr <= '0;
          r_count    <= '0;
        end else begin
          r_clr_addr <= r_clr_addr + FB_ADDR_W'(1);
        end
      end else if (r_s1_vld) begin
        if (r_s1_ok) begin
          r_wr_en <= 1'b1;
          r_addr  <= r_s1_addr;
          r_dat   <= r_s1_dat;
          if (r_count == PIX_LAST) begin
            r_count <= '0;
            r_fdone <= 1'b1;
          end else begin
            r_count <= r_count + FB_ADDR_W'(1);
          end
        end else begin
          r_drop <= 1'b1;
        end
      end
    end
  end

  assign pix_bus.oPix_ready = w_ready;
  assign pix_bus.oWR_en     = r_wr_en;
  assign pix_bus.oADDR      = r_addr;
  assign pix_bus.oDATA      = r_dat;
  assign oBusy              = (r_state != ST_RUN);
  assign oDrop              = r_drop;
  assign oFrame_done        = r_fdone;
  assign oPix_count         = r_count;
endmodule

// File: tb/tb_engine2vga_writer.sv
// Bench for engine2vga_writer on a 640x16 screen: fixed vectors, random traffic against a queue model,
// a full frame, a clear with held-high input, and resets mid-frame and mid-clear.
`timescale 1ns/1ps
module tb_engine2vga_writer;
  import engine2vga_writer_pkg::*;

  localparam int H = 640;
  localparam int V = 16;
  localparam int TOTAL = H * V;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [ITER_W-1:0]    max_iter = 16'd100;
  logic                 clr = 1'b0;
  logic                 busy, drop, fd;
  logic [FB_ADDR_W-1:0] cnt;

  engine2vga_writer_if bus ();

  engine2vga_writer #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(4)) dut (
    .clk_iCLK    (clk),
    .iRST_N      (rst_n),
    .iMax_iter   (max_iter),
    .iClear      (clr),
    .pix_bus     (bus),
    .oBusy       (busy),
    .oDrop       (drop),
    .oFrame_done (fd),
    .oPix_count  (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_drop;
    int addr;
    int dat;
    bit fdone;
    int count;
    bit clr;
    bit clr_last;
  } exp_t;

  typedef struct {
    int x; int y; int iter; int mx;
    bit drop; int addr; int dat;
  } vec_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0, n_err = 0;
  int   m_count = 0;
  bit   mon_en = 0;
  int   cyc = 0, n_wr = 0, n_fd = 0, last_wr_cyc = 0, busy_rdy_viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference colour rule, stated arithmetically.
  function automatic int ref_index(input int iter, input int mx);
    if (iter >= mx) return 0;
    if (iter % 256 == 0) return 255;
    return iter % 256;
  endfunction

  task automatic model_accept(input int x, input int y, input int iter);
    exp_t e;
    e = '{default: 0};
    if (x >= H || y >= V) begin
      e.is_drop = 1;
      e.count   = m_count;
    end else begin
      e.addr = y * H + x;
      e.dat  = ref_index(iter, int'(max_iter));
      m_count++;
      if (m_count == TOTAL) begin
        m_count = 0;
        e.fdone = 1;
      end
      e.count = m_count;
    end
    q.push_back(e);
  endtask

  task automatic model_clear();
    exp_t e;
    for (int i = 0; i < TOTAL; i++) begin
      e = '{default: 0};
      e.addr     = i;
      e.clr      = 1;
      e.clr_last = (i == TOTAL - 1);
      e.count    = (i == TOTAL - 1) ? 0 : m_count;
      q.push_back(e);
    end
    m_count = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (busy && bus.oPix_ready) busy_rdy_viol++;
      if (fd) begin
        n_fd++;
        chk("frame_done_without_write", bus.oWR_en, 1);
      end
      if (bus.oWR_en || drop) begin
        if (q.size() == 0) begin
          chk("unexpected_output", bus.oWR_en | drop, 0);
        end else begin
          m_e = q.pop_front();
          chk("drop_flag", drop, m_e.is_drop);
          chk("wr_en", bus.oWR_en, !m_e.is_drop);
          if (!m_e.is_drop) begin
            chk("addr", bus.oADDR, m_e.addr);
            chk("data", bus.oDATA, m_e.dat);
            chk("frame_done", fd, m_e.fdone);
            n_wr++;
            last_wr_cyc = cyc;
          end
          chk("pix_count", cnt, m_e.count);
          if (m_e.clr && !m_e.clr_last) chk("busy_during_clear", busy, 1);
        end
      end
    end
  end

  task automatic neg();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int x, input int y, input int iter, output bit acc);
    bus.iPix_valid = v;
    bus.iPix_x     = X_W'(x);
    bus.iPix_y     = Y_W'(y);
    bus.iPix_iter  = ITER_W'(iter);
    acc = v && bus.oPix_ready;
    if (acc) model_accept(x, y, iter);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      neg();
      n++;
    end
    chk({tag, "_drain"}, q.size(), 0);
  endtask

  task automatic async_reset_check(input string tag);
    mon_en = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_wr_en"}, bus.oWR_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_count"}, cnt, 0);
    chk({tag, "_ready"}, bus.oPix_ready, 0);
    chk({tag, "_drop"}, drop, 0);
    q.delete();
    m_count = 0;
    neg();
    rst_n = 1'b1;
    neg();
    chk({tag, "_ready_after_release"}, bus.oPix_ready, 1);
    mon_en = 1;
  endtask

  task automatic random_phase(input int ncyc, input int mx);
    bit acc;
    int x, y, it;
    max_iter = ITER_W'(mx);
    for (int c = 0; c < ncyc; c++) begin
      neg();
      x  = ($urandom_range(0, 15) == 0) ? H + $urandom_range(0, 383) : $urandom_range(0, H - 1);
      y  = ($urandom_range(0, 15) == 0) ? V + $urandom_range(0, 200) : $urandom_range(0, V - 1);
      it = ($urandom_range(0, 5) == 0) ? 256 * $urandom_range(0, 3) : $urandom_range(0, 700);
      drive($urandom_range(0, 3) != 0, x, y, it, acc);
    end
    neg();
    drive(0, 0, 0, 0, acc);
    wait_drain("random", 50);
  endtask

  vec_t tbl[10];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, got;
    int lat, t_count, c_start, wr0, fd0;

    bus.iPix_valid = 0;
    bus.iPix_x = '0;
    bus.iPix_y = '0;
    bus.iPix_iter = '0;

    // Reset state
    repeat (3) neg();
    chk("rst_ready", bus.oPix_ready, 0);
    chk("rst_wr_en", bus.oWR_en, 0);
    chk("rst_addr", bus.oADDR, 0);
    chk("rst_data", bus.oDATA, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_fdone", fd, 0);
    chk("rst_count", cnt, 0);
    rst_n = 1'b1;
    chk("ready_before_first_edge", bus.oPix_ready, 0);
    neg();
    chk("ready_after_first_edge", bus.oPix_ready, 1);

    // Directed vectors: {x, y, iter, max, drop, addr, data}
    tbl[0] = '{3, 2, 10, 100, 0, 1283, 10};
    tbl[1] = '{0, 0, 100, 100, 0, 0, 0};
    tbl[2] = '{1, 0, 256, 1000, 0, 1, 255};
    tbl[3] = '{2, 0, 300, 1000, 0, 2, 44};
    tbl[4] = '{640, 0, 7, 100, 1, 0, 0};
    tbl[5] = '{0, 15, 7, 100, 0, 9600, 7};
    tbl[6] = '{639, 15, 1, 0, 0, 10239, 0};
    tbl[7] = '{5, 1, 255, 256, 0, 645, 255};
    tbl[8] = '{0, 16, 3, 100, 1, 0, 0};
    tbl[9] = '{639, 0, 99, 100, 0, 639, 99};
    t_count = 0;
    for (int i = 0; i < 10; i++) begin
      neg();
      max_iter = ITER_W'(tbl[i].mx);
      bus.iPix_valid = 1;
      bus.iPix_x = X_W'(tbl[i].x);
      bus.iPix_y = Y_W'(tbl[i].y);
      bus.iPix_iter = ITER_W'(tbl[i].iter);
      chk("tbl_ready", bus.oPix_ready, 1);
      @(posedge clk);
      #1 bus.iPix_valid = 0;
      got = 0;
      lat = 0;
      for (int c = 1; c <= 8 && !got; c++) begin
        @(negedge clk);
        if (bus.oWR_en || drop) begin
          got = 1;
          lat = c;
        end
      end
      chk("tbl_latency", lat, 3);
      if (got) begin
        if (!tbl[i].drop) t_count++;
        chk("tbl_drop", drop, tbl[i].drop);
        chk("tbl_wr_en", bus.oWR_en, !tbl[i].drop);
        if (!tbl[i].drop) begin
          chk("tbl_addr", bus.oADDR, tbl[i].addr);
          chk("tbl_data", bus.oDATA, tbl[i].dat);
        end
        chk("tbl_count", cnt, t_count);
      end
      repeat (2) neg();
    end

    // Random traffic against the queue model
    m_count = t_count;
    mon_en = 1;
    random_phase(3000, 300);
    random_phase(2000, $urandom_range(1, 700));
    async_reset_check("frame_reset");

    // Full frame, valid held high
    wr0 = n_wr;
    fd0 = n_fd;
    busy_rdy_viol = 0;
    lat = 0;
    c_start = 0;
    for (int i = 0; i < TOTAL; i++) begin
      neg();
      if (i == 0) c_start = cyc;
      drive(1, i % H, i / H, $urandom_range(0, 600), acc);
      if (!acc) lat++;
    end
    neg();
    drive(0, 0, 0, 0, acc);
    wait_drain("frame", 50);
    chk("frame_ready_drops", lat, 0);
    chk("frame_writes", n_wr - wr0, TOTAL);
    chk("frame_span", last_wr_cyc - c_start, TOTAL + 2);
    chk("frame_done_pulses", n_fd - fd0, 1);
    chk("frame_count_wrap", cnt, 0);

    // Clear mid-stream; later clear pulses land in DRAIN/CLEAR and must be ignored
    fd0 = n_fd;
    for (int i = 0; i < TOTAL + 150; i++) begin
      neg();
      clr = (i == 20) || (i == 22) || (i == 25) || (i == 5000);
      if (i == 20) chk("clear_issue_ready", bus.oPix_ready, 1);
      drive(1, $urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, 600), acc);
      if (i == 20 && acc) model_clear();
    end
    neg();
    clr = 0;
    drive(0, 0, 0, 0, acc);
    wait_drain("clear", 50);
    chk("clear_no_frame_done", n_fd - fd0, 0);
    chk("busy_ready_overlap", busy_rdy_viol, 0);
    chk("clear_idle_busy", busy, 0);

    // Reset in the middle of a clear
    neg();
    clr = 1;
    chk("clear2_issue_ready", bus.oPix_ready, 1);
    model_clear();
    neg();
    clr = 0;
    repeat (150) neg();
    chk("pre_reset_clear_wr_en", bus.oWR_en, 1);
    chk("pre_reset_busy", busy, 1);
    async_reset_check("clear_reset");
    neg();
    drive(1, 3, 2, 10, acc);
    chk("post_reset_accept", acc, 1);
    neg();
    drive(0, 0, 0, 0, acc);
    wait_drain("post_reset", 20);
    chk("post_reset_count", cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
